// File: rtl/fetch_pkg.sv
// fetch_pkg: state type, line geometry and helpers shared by the fetch scheduler.
// Line geometry constants describe the default 8-beat configuration.
package fetch_pkg;

   typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} fetch_state_t;

   localparam int unsigned DEF_BEATS      = 8;
   localparam int unsigned LINE_BYTES     = DEF_BEATS * 8;
   localparam int unsigned SLOTS_PER_LINE = 2 * DEF_BEATS;
   localparam int unsigned SLOT_W         = $clog2(SLOTS_PER_LINE);
   localparam logic [31:0] ZERO_INSN      = '0;

   function automatic int unsigned line_bytes(input int unsigned beats);
      return beats * 8;
   endfunction

   function automatic int unsigned slot_w(input int unsigned beats);
      return $clog2(2 * beats);
   endfunction

   function automatic int unsigned beat_w(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// fetch_line_buf: one instruction line held as BEATS x 64-bit beats, written a
// beat at a time and read back as 32-bit slots without a clock delay.
module fetch_line_buf
   import fetch_pkg::*;
#(
   parameter int unsigned BEATS = DEF_BEATS
)(
   input  logic                       clk,
   input  logic                       we,
   input  logic [beat_w(BEATS)-1:0]   waddr,
   input  logic [63:0]                wdata,
   input  logic [slot_w(BEATS)-1:0]   slot,
   output logic [31:0]                rdata
);

   localparam int unsigned BW = beat_w(BEATS);

   logic [63:0] mem [BEATS];
   logic [63:0] line_word;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Even slots live in the low half of a beat, odd slots in the high half.
   assign line_word = mem[BW'(slot >> 1)];
   assign rdata     = slot[0] ? line_word[63:32] : line_word[31:0];

endmodule

// File: rtl/fetch_sched.sv
// fetch_sched: requests instruction lines, buffers each burst and feeds the
// decoder one word per cycle until an all-zero word. Define FETCH_TRACE_EN for a transfer trace.
module fetch_sched
   import fetch_pkg::*;
#(
   parameter int unsigned BEATS  = DEF_BEATS,
   parameter int unsigned ADDR_W = 64
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] entry_pc,
   output logic              bus_reqcyc,
   output logic [ADDR_W-1:0] bus_req,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [63:0]       bus_resp,
   output logic              bus_respack,
   output logic              dec_valid,
   output logic [31:0]       dec_insn,
   output logic [ADDR_W-1:0] dec_pc,
   input  logic              dec_ready,
   output logic              busy,
   output logic              halted
);

   localparam int unsigned LB  = line_bytes(BEATS);
   localparam int unsigned OFF = $clog2(LB);
   localparam int unsigned SW  = slot_w(BEATS);
   localparam int unsigned BW  = beat_w(BEATS);
   localparam logic [SW-1:0] LAST_SLOT = SW'(2 * BEATS - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   fetch_state_t      state;
   logic [ADDR_W-1:0] line_addr;
   logic [SW-1:0]     slot;
   logic [BW-1:0]     beat_cnt;
   logic [31:0]       cur_word;
   logic [ADDR_W-1:0] cur_pc;
   logic              in_drain;
   logic              word_zero;
   logic              beat_take;
   logic              unused_pc_lsb;

   assign unused_pc_lsb = ^entry_pc[1:0];
   assign in_drain      = (state == DRAIN);
   assign word_zero     = (cur_word == ZERO_INSN);
   assign beat_take     = (state == RESP) && bus_respcyc;
   assign cur_pc        = line_addr + ADDR_W'({slot, 2'b00});

   fetch_line_buf #(.BEATS(BEATS)) u_buf (
      .clk   (clk),
      .we    (beat_take),
      .waddr (beat_cnt),
      .wdata (bus_resp),
      .slot  (slot),
      .rdata (cur_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         line_addr <= '0;
         slot      <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  line_addr <= {entry_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                  slot      <= entry_pc[OFF-1:2];
                  beat_cnt  <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (bus_reqack) state <= RESP;
            end
            RESP: begin
               if (bus_respcyc) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // A zero word halts even if the decoder is ready this cycle.
               if (word_zero) begin
                  state <= HALT;
               end else if (dec_ready) begin
                  if (slot == LAST_SLOT) begin
                     line_addr <= line_addr + ADDR_W'(LB);
                     slot      <= '0;
                     state     <= REQ;
                  end else begin
                     slot <= slot + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus_reqcyc  = (state == REQ);
   assign bus_req     = bus_reqcyc ? line_addr : '0;
   assign bus_respack = beat_take;
   assign dec_valid   = in_drain && !word_zero;
   assign dec_insn    = dec_valid ? cur_word : '0;
   assign dec_pc      = dec_valid ? cur_pc : '0;
   assign busy        = !(state == IDLE || state == HALT);
   assign halted      = (state == HALT);

`ifdef FETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (reset_n && dec_valid && dec_ready)
         $display("%016h: %08h", dec_pc, dec_insn);
      if (reset_n && in_drain && word_zero)
         $display("%016h: halt", cur_pc);
   end
`else
`endif

endmodule
